uart_cmd_parser: RTL and testbench

- Sits directly downstream of the UART receiver and upstream of the UART transmitter in the ISP control path.
- Turns the received byte stream into fixed-length register-access frames and drives a simple register bus for ISP configuration.
- Serialises the ack/read-response bytes back out through the transmitter's valid/ready handshake.
- Checks frame sync, command code, XOR checksum and inter-byte timeout.

---
 rtl/uart_cmd_parser.sv | 230 +++++++++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_parser.sv
// Register-access command parser between the UART receiver and transmitter.
// Decodes 6-byte SYNC/CMD/ADDR/DH/DL/CHK frames, drives the register bus and returns ACK/NAK/read data.
module uart_cmd_parser #(
    parameter int unsigned CLK_FRE    = 50,
    parameter int unsigned TIMEOUT_US = 2000,
    parameter logic [7:0]  SYNC_BYTE  = 8'h55,
    parameter logic [7:0]  ACK_BYTE   = 8'hAC,
    parameter logic [7:0]  NAK_BYTE   = 8'hEE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_data_valid,
    output logic        rx_data_ready,
    output logic [7:0]  tx_data,
    output logic        tx_data_valid,
    input  logic        tx_data_ready,
    output logic        reg_wr_en,
    output logic        reg_rd_en,
    output logic [7:0]  reg_addr,
    output logic [15:0] reg_wdata,
    input  logic [15:0] reg_rdata,
    output logic [7:0]  err_cnt
);

    localparam int unsigned TimeoutCycles = (CLK_FRE * TIMEOUT_US < 1) ? 1 : CLK_FRE * TIMEOUT_US;
    localparam int unsigned TmoW          = $clog2(TimeoutCycles + 1);
    localparam logic [7:0]  CmdWrite      = 8'h01;
    localparam logic [7:0]  CmdRead       = 8'h02;

    typedef enum logic [3:0] {
        StHunt, StCmd, StAddr, StDh, StDl, StChk, StExec, StRdcap, StResp
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      cmd_q, cmd_d;
    logic [7:0]      addr_q, addr_d;
    logic [7:0]      dh_q, dh_d;
    logic [7:0]      dl_q, dl_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic            rx_ready_q, rx_ready_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_valid_q, tx_valid_d;
    logic [31:0]     resp_buf_q, resp_buf_d;
    logic [2:0]      resp_left_q, resp_left_d;
    logic            wr_en_q, wr_en_d;
    logic            rd_en_q, rd_en_d;
    logic [7:0]      reg_addr_q, reg_addr_d;
    logic [15:0]     reg_wdata_q, reg_wdata_d;
    logic [7:0]      err_q, err_d;

    logic       accept;
    logic       in_frame;
    logic       frame_ok;
    logic [7:0] err_inc;
    logic [7:0] rd_chk;

    assign accept   = rx_data_valid && rx_ready_q;
    assign in_frame = (state_q == StCmd) || (state_q == StAddr) || (state_q == StDh) ||
                      (state_q == StDl) || (state_q == StChk);
    assign frame_ok = (rx_data == (cmd_q ^ addr_q ^ dh_q ^ dl_q)) &&
                      ((cmd_q == CmdWrite) || (cmd_q == CmdRead));
    assign err_inc  = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
    assign rd_chk   = addr_q ^ reg_rdata[15:8] ^ reg_rdata[7:0];

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        addr_d      = addr_q;
        dh_d        = dh_q;
        dl_d        = dl_q;
        tmo_d       = tmo_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        resp_buf_d  = resp_buf_q;
        resp_left_d = resp_left_q;
        wr_en_d     = 1'b0;
        rd_en_d     = 1'b0;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        err_d       = err_q;

        unique case (state_q)
            StHunt: begin
                if (accept && (rx_data == SYNC_BYTE)) begin
                    state_d = StCmd;
                end
            end
            StCmd: begin
                if (accept) begin
                    cmd_d   = rx_data;
                    state_d = StAddr;
                end
            end
            StAddr: begin
                if (accept) begin
                    addr_d  = rx_data;
                    state_d = StDh;
                end
            end
            StDh: begin
                if (accept) begin
                    dh_d    = rx_data;
                    state_d = StDl;
                end
            end
            StDl: begin
                if (accept) begin
                    dl_d    = rx_data;
                    state_d = StChk;
                end
            end
            StChk: begin
                if (accept) begin
                    if (frame_ok) begin
                        state_d    = StExec;
                        reg_addr_d = addr_q;
                        if (cmd_q == CmdWrite) begin
                            wr_en_d     = 1'b1;
                            reg_wdata_d = {dh_q, dl_q};
                        end else begin
                            rd_en_d = 1'b1;
                        end
                    end else begin
                        state_d     = StResp;
                        tx_valid_d  = 1'b1;
                        tx_data_d   = NAK_BYTE;
                        resp_left_d = 3'd0;
                        err_d       = err_inc;
                    end
                end
            end
            StExec: begin
                if (cmd_q == CmdWrite) begin
                    state_d     = StResp;
                    tx_valid_d  = 1'b1;
                    tx_data_d   = ACK_BYTE;
                    resp_left_d = 3'd0;
                end else begin
                    state_d = StRdcap;
                end
            end
            StRdcap: begin
                // reg_rdata is valid in this cycle only, one cycle after the read strobe.
                state_d     = StResp;
                tx_valid_d  = 1'b1;
                tx_data_d   = SYNC_BYTE;
                resp_buf_d  = {addr_q, reg_rdata, rd_chk};
                resp_left_d = 3'd4;
            end
            StResp: begin
                if (tx_valid_q && tx_data_ready) begin
                    if (resp_left_q == 3'd0) begin
                        tx_valid_d = 1'b0;
                        state_d    = StHunt;
                    end else begin
                        tx_data_d   = resp_buf_q[31:24];
                        resp_buf_d  = {resp_buf_q[23:0], 8'h00};
                        resp_left_d = resp_left_q - 3'd1;
                    end
                end
            end
            default: begin
                state_d = StHunt;
            end
        endcase

        // Idle-gap watchdog; an accepted byte always wins over expiry.
        if (!in_frame || accept) begin
            tmo_d = '0;
        end else if (tmo_q == TmoW'(TimeoutCycles - 1)) begin
            tmo_d   = '0;
            state_d = StHunt;
            err_d   = err_inc;
        end else begin
            tmo_d = tmo_q + TmoW'(1);
        end

        rx_ready_d = (state_d == StHunt) || (state_d == StCmd) || (state_d == StAddr) ||
                     (state_d == StDh) || (state_d == StDl) || (state_d == StChk);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StHunt;
            cmd_q       <= 8'h00;
            addr_q      <= 8'h00;
            dh_q        <= 8'h00;
            dl_q        <= 8'h00;
            tmo_q       <= '0;
            rx_ready_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            tx_valid_q  <= 1'b0;
            resp_buf_q  <= 32'h0;
            resp_left_q <= 3'd0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            reg_addr_q  <= 8'h00;
            reg_wdata_q <= 16'h0000;
            err_q       <= 8'h00;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            dh_q        <= dh_d;
            dl_q        <= dl_d;
            tmo_q       <= tmo_d;
            rx_ready_q  <= rx_ready_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            resp_buf_q  <= resp_buf_d;
            resp_left_q <= resp_left_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            err_q       <= err_d;
        end
    end

    assign rx_data_ready = rx_ready_q;
    assign tx_data       = tx_data_q;
    assign tx_data_valid = tx_valid_q;
    assign reg_wr_en     = wr_en_q;
    assign reg_rd_en     = rd_en_q;
    assign reg_addr      = reg_addr_q;
    assign reg_wdata     = reg_wdata_q;
    assign err_cnt       = err_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: frame-level model plus per-cycle compare process.
module tb_uart_cmd_parser;

    localparam int unsigned ClkFre    = 1;
    localparam int unsigned TimeoutUs = 40;
    localparam int unsigned Limit     = ClkFre * TimeoutUs;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_data_valid = 1'b0;
    logic        rx_data_ready;
    logic [7:0]  tx_data;
    logic        tx_data_valid;
    logic        tx_data_ready = 1'b1;
    logic        reg_wr_en;
    logic        reg_rd_en;
    logic [7:0]  reg_addr;
    logic [15:0] reg_wdata;
    logic [15:0] reg_rdata = 16'h0000;
    logic [7:0]  err_cnt;

    uart_cmd_parser #(
        .CLK_FRE    (ClkFre),
        .TIMEOUT_US (TimeoutUs)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_data       (rx_data),
        .rx_data_valid (rx_data_valid),
        .rx_data_ready (rx_data_ready),
        .tx_data       (tx_data),
        .tx_data_valid (tx_data_valid),
        .tx_data_ready (tx_data_ready),
        .reg_wr_en     (reg_wr_en),
        .reg_rd_en     (reg_rd_en),
        .reg_addr      (reg_addr),
        .reg_wdata     (reg_wdata),
        .reg_rdata     (reg_rdata),
        .err_cnt       (err_cnt)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Register-bus responder: data is valid only in the cycle after the read strobe.
    logic [15:0] rd_value = 16'h0000;
    always @(posedge clk) reg_rdata <= reg_rd_en ? rd_value : 16'hDEAD;

    typedef struct packed {
        logic        wr;
        logic [7:0]  addr;
        logic [15:0] wdata;
    } strobe_t;

    logic [7:0]  fq[$];
    logic [7:0]  exp_tx[$];
    logic [7:0]  got_tx[$];
    strobe_t     exp_str[$];
    int unsigned exp_str_cyc[$];
    int unsigned exp_first[$];
    int unsigned model_err = 0;
    logic [7:0]  model_addr = 8'h00;
    logic [15:0] model_wdata = 16'h0000;
    logic        chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Frame-level model: evaluates a whole frame once its sixth byte is taken.
    task automatic model_byte(input logic [7:0] b, input int unsigned acc);
        logic [7:0] cmd, addr, dh, dl, chk;
        strobe_t    s;
        if (fq.size() == 0 && b != 8'h55) return;
        fq.push_back(b);
        if (fq.size() < 6) return;
        cmd = fq[1]; addr = fq[2]; dh = fq[3]; dl = fq[4]; chk = fq[5];
        fq.delete();
        if (chk == (cmd ^ addr ^ dh ^ dl) && (cmd == 8'h01 || cmd == 8'h02)) begin
            model_addr = addr;
            if (cmd == 8'h01) model_wdata = {dh, dl};
            s.wr = (cmd == 8'h01); s.addr = addr; s.wdata = model_wdata;
            exp_str.push_back(s);
            exp_str_cyc.push_back(acc);
            if (cmd == 8'h01) begin
                exp_tx.push_back(8'hAC);
                exp_first.push_back(acc + 1);
            end else begin
                exp_tx.push_back(8'h55);
                exp_tx.push_back(addr);
                exp_tx.push_back(rd_value[15:8]);
                exp_tx.push_back(rd_value[7:0]);
                exp_tx.push_back(addr ^ rd_value[15:8] ^ rd_value[7:0]);
                exp_first.push_back(acc + 2);
            end
        end else begin
            exp_tx.push_back(8'hEE);
            exp_first.push_back(acc);
            if (model_err < 255) model_err++;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int unsigned n;
        n = 0;
        rx_data = b;
        rx_data_valid = 1'b1;
        @(negedge clk);
        while (!rx_data_ready && n < 2000) begin
            n++;
            @(negedge clk);
        end
        if (!rx_data_ready) begin
            check("rx_accept_wait", rx_data_ready, 1);
            rx_data_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        rx_data_valid = 1'b0;
        model_byte(b, cyc);
    endtask

    task automatic send_frame(input logic [47:0] f);
        for (int i = 5; i >= 0; i--) send_byte(f[i*8 +: 8]);
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
        if (n >= 2 * Limit && fq.size() != 0) begin
            fq.delete();
            if (model_err < 255) model_err++;
        end
    endtask

    task automatic wait_done();
        int unsigned n;
        n = 0;
        @(negedge clk);
        while ((exp_tx.size() != 0 || exp_str.size() != 0 || tx_data_valid) && n < 5000) begin
            n++;
            @(negedge clk);
        end
        if (n >= 5000) check("drain_pending", exp_tx.size() + exp_str.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string name);
        check({name, "_err_cnt"}, err_cnt, model_err);
        check({name, "_reg_addr"}, reg_addr, model_addr);
        check({name, "_reg_wdata"}, reg_wdata, model_wdata);
    endtask

    // Per-cycle compare against the model's expectation queues.
    strobe_t     cs;
    logic        prev_valid = 1'b0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = 8'h00;
    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            check("rx_ready", rx_data_ready, (exp_tx.size() == 0 && exp_str.size() == 0));
            check("strobe_exclusive", reg_wr_en & reg_rd_en, 0);
            if (reg_wr_en || reg_rd_en) begin
                if (exp_str.size() == 0) begin
                    check("unexpected_strobe", {reg_wr_en, reg_rd_en}, 0);
                end else begin
                    cs = exp_str.pop_front();
                    check("strobe_kind", reg_wr_en, cs.wr);
                    check("strobe_addr", reg_addr, cs.addr);
                    check("strobe_wdata", reg_wdata, cs.wdata);
                    check("strobe_cycle", cyc, exp_str_cyc.pop_front());
                end
            end
            if (tx_data_valid && !prev_valid) begin
                if (exp_first.size() == 0) check("unexpected_tx_start", tx_data_valid, 0);
                else check("tx_first_cycle", cyc, exp_first.pop_front());
            end
            if (prev_stall) begin
                check("tx_hold_valid", tx_data_valid, 1);
                check("tx_hold_data", tx_data, prev_data);
            end
            if (tx_data_valid && tx_data_ready) begin
                got_tx.push_back(tx_data);
                if (exp_tx.size() == 0) check("unexpected_tx", tx_data_valid, 0);
                else check("tx_byte", tx_data, exp_tx.pop_front());
            end
            prev_stall = tx_data_valid && !tx_data_ready;
            prev_valid = tx_data_valid;
            prev_data  = tx_data;
        end else begin
            prev_stall = 1'b0;
            prev_valid = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        #12;
        check("rst_rx_ready", rx_data_ready, 0);
        check("rst_tx_valid", tx_data_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_strobes", {reg_wr_en, reg_rd_en}, 0);
        check("rst_addr", reg_addr, 0);
        check("rst_wdata", reg_wdata, 0);
        check("rst_err", err_cnt, 0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        check("rel_rx_ready", rx_data_ready, 1);
        chk_en = 1'b1;
        @(posedge clk); #1;

        // Write frame
        got_tx.delete();
        send_frame(48'h55_01_10_12_34_37);
        wait_done();
        check("wr_tx_count", got_tx.size(), 1);
        check("wr_tx_ack", got_tx[0], 8'hAC);
        check("wr_addr", reg_addr, 8'h10);
        check("wr_wdata", reg_wdata, 16'h1234);
        check("wr_err", err_cnt, 0);
        check_quiet("wr");

        // Read frame
        got_tx.delete();
        rd_value = 16'hBEEF;
        send_frame(48'h55_02_20_00_00_22);
        wait_done();
        check("rd_tx_count", got_tx.size(), 5);
        check("rd_tx0", got_tx[0], 8'h55);
        check("rd_tx1", got_tx[1], 8'h20);
        check("rd_tx2", got_tx[2], 8'hBE);
        check("rd_tx3", got_tx[3], 8'hEF);
        check("rd_tx4", got_tx[4], 8'h71);
        check("rd_wdata_held", reg_wdata, 16'h1234);
        check_quiet("rd");

        // Bad checksum
        got_tx.delete();
        send_frame(48'h55_01_10_12_34_00);
        wait_done();
        check("bad_tx", got_tx[0], 8'hEE);
        check("bad_err", err_cnt, 1);
        check_quiet("bad");

        // Sync hunt
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h13);
        send_frame(48'h55_01_10_12_34_37);
        wait_done();
        check("hunt_err", err_cnt, 1);
        check_quiet("hunt");

        // Unknown command with a correct checksum
        send_frame(48'h55_03_10_12_34_35);
        wait_done();
        check_quiet("badcmd");

        // SYNC bytes inside the frame are data
        send_frame(48'h55_01_55_55_00_01);
        wait_done();
        check("midsync_addr", reg_addr, 8'h55);
        check("midsync_wdata", reg_wdata, 16'h5500);
        check_quiet("midsync");

        // Gaps just under the timeout keep the frame alive
        send_byte(8'h55); idle(Limit - 5); send_byte(8'h01); idle(Limit - 5);
        send_byte(8'h40); idle(Limit - 5); send_byte(8'h00); idle(Limit - 5);
        send_byte(8'h07); idle(Limit - 5); send_byte(8'h46);
        wait_done();
        check("gap_wdata", reg_wdata, 16'h0007);
        check_quiet("gap");

        // Timeout: remaining bytes fall into hunt
        got_tx.delete();
        send_byte(8'h55); send_byte(8'h01); send_byte(8'h10);
        idle(3 * Limit);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h37);
        wait_done();
        check("tmo_tx_count", got_tx.size(), 0);
        check("tmo_err", err_cnt, 3);
        check_quiet("tmo");

        // Backpressure during a read response
        got_tx.delete();
        rd_value = 16'hA5C3;
        tx_data_ready = 1'b0;
        send_frame(48'h55_02_33_11_22_02);
        repeat (500) @(posedge clk);
        for (int i = 0; i < 24; i++) begin
            @(posedge clk); #1;
            tx_data_ready = (i % 3 == 2);
        end
        tx_data_ready = 1'b1;
        wait_done();
        check("bp_tx_count", got_tx.size(), 5);
        check("bp_tx0", got_tx[0], 8'h55);
        check("bp_tx1", got_tx[1], 8'h33);
        check("bp_tx2", got_tx[2], 8'hA5);
        check("bp_tx3", got_tx[3], 8'hC3);
        check("bp_tx4", got_tx[4], 8'h55);
        check_quiet("bp");

        // Error counter saturation
        for (int i = 0; i < 300; i++) begin
            send_frame(48'h55_01_10_12_34_00);
            wait_done();
        end
        check("sat_err", err_cnt, 255);
        check_quiet("sat");

        // Reset in the middle of a read response
        got_tx.delete();
        rd_value = 16'h1357;
        send_frame(48'h55_02_44_00_00_46);
        begin
            int unsigned n;
            n = 0;
            @(negedge clk);
            while (got_tx.size() < 2 && n < 200) begin
                n++;
                @(negedge clk);
            end
            if (got_tx.size() < 2) check("midrst_progress", got_tx.size(), 2);
        end
        @(posedge clk); #1;
        chk_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_tx_valid", tx_data_valid, 0);
        check("midrst_rx_ready", rx_data_ready, 0);
        check("midrst_err", err_cnt, 0);
        fq.delete(); exp_tx.delete(); exp_str.delete(); exp_str_cyc.delete(); exp_first.delete();
        model_err = 0; model_addr = 8'h00; model_wdata = 16'h0000;
        repeat (3) @(posedge clk);
        #1; rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        check("midrst_rel_ready", rx_data_ready, 1);
        check("midrst_rel_valid", tx_data_valid, 0);
        chk_en = 1'b1;
        @(posedge clk); #1;
        got_tx.delete();
        send_frame(48'h55_01_10_12_34_37);
        wait_done();
        check("post_rst_tx", got_tx[0], 8'hAC);
        check("post_rst_wdata", reg_wdata, 16'h1234);
        check_quiet("post_rst");

        repeat (4) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
